// File: rtl/vip_frame_stream_gen_if.sv
// Control inputs and pixel-stream outputs of the synthetic video source.
// The master modport is the generator side; the slave modport is the consumer side.
interface vip_frame_stream_gen_if;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        out_frame_vsync;
  logic        out_frame_href;
  logic        out_frame_clken;
  logic [7:0]  out_img_Y;
  logic [15:0] frame_cnt;
  logic        busy;

  modport master (
    input  enable, pattern_sel,
    output out_frame_vsync, out_frame_href, out_frame_clken, out_img_Y, frame_cnt, busy
  );

  modport slave (
    output enable, pattern_sel,
    input  out_frame_vsync, out_frame_href, out_frame_clken, out_img_Y, frame_cnt, busy
  );
endinterface

// File: rtl/vip_frame_stream_gen.sv
// Synthetic vsync/href/clken/Y frame source with programmable timing and four test patterns.
// Every output is registered, so it lags the internal state decode by one clock.
module vip_frame_stream_gen #(
  parameter int unsigned IMG_HDISP   = 640,
  parameter int unsigned IMG_VDISP   = 480,
  parameter int unsigned H_BLANK     = 160,
  parameter int unsigned VSYNC_LINES = 2,
  parameter int unsigned V_BACK      = 10,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned CLK_DIV     = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  vip_frame_stream_gen_if.master strm
);

  localparam logic [15:0] HLast      = 16'(IMG_HDISP + H_BLANK - 1);
  localparam logic [15:0] HDisp      = 16'(IMG_HDISP);
  localparam logic [3:0]  DivLast    = 4'(CLK_DIV - 1);
  localparam logic [15:0] VsyncLast  = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VbackLast  = 16'((V_BACK == 0) ? 0 : V_BACK - 1);
  localparam logic [15:0] VdispLast  = 16'(IMG_VDISP - 1);
  localparam logic [15:0] VfrontLast = 16'((V_FRONT == 0) ? 0 : V_FRONT - 1);

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  state_e      state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [15:0] h_q, h_d;
  logic [15:0] line_q, line_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        tick, line_end, frame_end;
  logic        href_d, clken_d;
  logic [7:0]  pix, y_d;

  logic        vsync_q, href_q, clken_q, busy_q;
  logic [7:0]  y_q;
  logic [15:0] fcnt_out_q;

  assign tick     = (div_q == DivLast);
  assign line_end = tick && (h_q == HLast);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    fcnt_d    = fcnt_q;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strm.enable) begin
          state_d = StVsync;
          pat_d   = strm.pattern_sel;
        end
      end
      StVsync: begin
        if (line_end && line_q == VsyncLast) state_d = (V_BACK != 0) ? StVback : StActive;
      end
      StVback: begin
        if (line_end && line_q == VbackLast) state_d = StActive;
      end
      StActive: begin
        if (line_end && line_q == VdispLast) begin
          if (V_FRONT != 0) state_d = StVfront;
          else              frame_end = 1'b1;
        end
      end
      StVfront: begin
        if (line_end && line_q == VfrontLast) frame_end = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // Enable is only consulted here, so a frame in flight always completes.
    if (frame_end) begin
      fcnt_d = fcnt_q + 16'd1;
      if (strm.enable) begin
        state_d = StVsync;
        pat_d   = strm.pattern_sel;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    div_d  = '0;
    h_d    = h_q;
    line_d = line_q;
    if (state_q != StIdle && state_d != StIdle && !tick) div_d = div_q + 4'd1;
    if (state_d != state_q || state_q == StIdle) begin
      h_d    = '0;
      line_d = '0;
    end else if (tick) begin
      if (h_q == HLast) begin
        h_d    = '0;
        line_d = line_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
    end
  end

  always_comb begin
    href_d  = (state_q == StActive) && (h_q < HDisp);
    clken_d = href_d && tick;
    pix     = 8'h00;
    unique case (pat_q)
      2'd0: pix = h_q[7:0];
      2'd1: pix = line_q[7:0];
      2'd2: pix = (h_q[3] ^ line_q[3]) ? 8'hFF : 8'h00;
      2'd3: pix = h_q[7:0] + fcnt_q[7:0];
      default: pix = 8'h00;
    endcase
    y_d = clken_d ? pix : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      h_q        <= '0;
      line_q     <= '0;
      pat_q      <= '0;
      fcnt_q     <= '0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      clken_q    <= 1'b0;
      y_q        <= 8'h00;
      fcnt_out_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      h_q        <= h_d;
      line_q     <= line_d;
      pat_q      <= pat_d;
      fcnt_q     <= fcnt_d;
      vsync_q    <= (state_q == StVsync);
      href_q     <= href_d;
      clken_q    <= clken_d;
      y_q        <= y_d;
      fcnt_out_q <= fcnt_q;
      busy_q     <= (state_q != StIdle);
    end
  end

  assign strm.out_frame_vsync = vsync_q;
  assign strm.out_frame_href  = href_q;
  assign strm.out_frame_clken = clken_q;
  assign strm.out_img_Y       = y_q;
  assign strm.frame_cnt       = fcnt_out_q;
  assign strm.busy            = busy_q;

endmodule
